// File: rtl/perif_uart_tx.sv
// UART transmitter peripheral: byte FIFO feeding an 8N1 serialiser (LSB first).
// The bit period comes from a run-time divisor that is latched at the start of each frame.
module perif_uart_tx #(
  parameter int p_fifo_depth_pw2 = 3
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_en,
  input  logic        i_wr_en,
  input  logic [15:0] i_baudrate,
  input  logic [7:0]  i_data_tx,
  output logic        o_tx_full,
  output logic        o_uart_tx
);

  localparam int PW    = p_fifo_depth_pw2;
  localparam int DEPTH = 1 << PW;
  localparam logic [PW:0] DEPTH_C = {1'b1, {PW{1'b0}}};

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  // ---------------- FIFO ----------------
  logic [7:0]    mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [PW:0]   count, count_d;
  logic          full_q;
  logic          wr_ok, pop;

  // Writes are judged against the registered full flag, even when a pop
  // frees a slot on the same edge.
  assign wr_ok   = i_en & i_wr_en & ~full_q;
  assign count_d = count + {{PW{1'b0}}, wr_ok} - {{PW{1'b0}}, pop};

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full_q <= 1'b0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)   rd_ptr <= rd_ptr + 1'b1;
      count  <= count_d;
      full_q <= (count_d == DEPTH_C);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst && wr_ok) mem[wr_ptr] <= i_data_tx;
  end

  // ---------------- serialiser ----------------
  state_t      state, state_d;
  logic [15:0] cnt, cnt_d;
  logic [15:0] div_q, div_d;
  logic [2:0]  bit_idx, bit_d;
  logic [7:0]  shift, shift_d;
  logic        tx_q, tx_d;
  logic        bit_end;

  assign bit_end = (cnt == div_q - 16'd1);

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      state   <= IDLE;
      cnt     <= '0;
      div_q   <= 16'd1;
      bit_idx <= '0;
      shift   <= '0;
      tx_q    <= 1'b1;
    end else begin
      state   <= state_d;
      cnt     <= cnt_d;
      div_q   <= div_d;
      bit_idx <= bit_d;
      shift   <= shift_d;
      tx_q    <= tx_d;
    end
  end

  // The line value is computed for the state being entered, so the pin is
  // driven straight from a flop.
  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    div_d   = div_q;
    bit_d   = bit_idx;
    shift_d = shift;
    tx_d    = tx_q;
    pop     = 1'b0;
    case (state)
      IDLE: begin
        tx_d  = 1'b1;
        cnt_d = '0;
        bit_d = '0;
        if (i_en && count != '0) begin
          pop     = 1'b1;
          shift_d = mem[rd_ptr];
          div_d   = (i_baudrate == 16'd0) ? 16'd1 : i_baudrate;
          state_d = START;
          tx_d    = 1'b0;
        end
      end
      START: begin
        if (bit_end) begin
          cnt_d   = '0;
          state_d = DATA;
          tx_d    = shift[0];
        end else begin
          cnt_d = cnt + 16'd1;
        end
      end
      DATA: begin
        if (bit_end) begin
          cnt_d = '0;
          if (bit_idx == 3'd7) begin
            bit_d   = '0;
            state_d = STOP;
            tx_d    = 1'b1;
          end else begin
            bit_d   = bit_idx + 3'd1;
            shift_d = shift >> 1;
            tx_d    = shift[1];
          end
        end else begin
          cnt_d = cnt + 16'd1;
        end
      end
      STOP: begin
        tx_d = 1'b1;
        if (bit_end) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt + 16'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign o_uart_tx = tx_q;
  assign o_tx_full = full_q;

endmodule

// File: tb/tb_perif_uart_tx.sv
// Bench for perif_uart_tx: frame-timer reference model checked every cycle,
// plus a line decoder that pins decoded bytes and frame spacing.
module tb_perif_uart_tx;
  localparam int PW = 3;
  localparam int D  = 1 << PW;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b0;
  logic        i_en = 1'b0;
  logic        i_wr_en = 1'b0;
  logic [15:0] i_baudrate = 16'd10;
  logic [7:0]  i_data_tx = 8'd0;
  logic        o_tx_full, o_uart_tx;

  always #5 i_clk = ~i_clk;

  perif_uart_tx #(.p_fifo_depth_pw2(PW)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_en(i_en), .i_wr_en(i_wr_en),
    .i_baudrate(i_baudrate), .i_data_tx(i_data_tx),
    .o_tx_full(o_tx_full), .o_uart_tx(o_uart_tx)
  );

  int errs = 0, checks = 0, cyc = 0;
  bit chk_on = 1'b0;

  always @(posedge i_clk) cyc++;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // Reference model: a frame is 10 bit slots of m_div cycles, then one idle cycle.
  logic [7:0] mq[$];
  logic       m_busy = 1'b0, m_tx = 1'b1, m_full = 1'b0, m_pop, m_wr;
  logic [7:0] m_byte;
  int         m_t = 0, m_div = 1;

  function automatic logic line_bit(logic [7:0] b, int t, int d);
    int k;
    k = t / d;
    if (k == 0) return 1'b0;
    else if (k <= 8) return b[k-1];
    else return 1'b1;
  endfunction

  always @(posedge i_clk) begin
    if (!i_rst) begin
      mq.delete();
      m_busy = 1'b0; m_t = 0; m_tx = 1'b1; m_full = 1'b0;
    end else begin
      m_pop = !m_busy && i_en && mq.size() != 0;
      m_wr  = i_en && i_wr_en && !m_full;
      if (m_busy) begin
        m_t++;
        if (m_t == 10 * m_div) begin m_busy = 1'b0; m_tx = 1'b1; end
        else m_tx = line_bit(m_byte, m_t, m_div);
      end else if (m_pop) begin
        m_byte = mq.pop_front();
        m_div  = (i_baudrate == 16'd0) ? 1 : int'(i_baudrate);
        m_busy = 1'b1; m_t = 0; m_tx = 1'b0;
      end
      if (m_wr) mq.push_back(i_data_tx);
      m_full = (mq.size() == D);
    end
  end

  always @(negedge i_clk) begin
    if (chk_on) begin
      chk("tx_line", o_uart_tx, m_tx);
      chk("tx_full", o_tx_full, m_full);
    end
  end

  // Independent decoder: samples mid-bit using the divisor the bench configured.
  bit         dec_on = 1'b0;
  int         d_div = 10, d_cnt = 0, dk;
  logic       d_act = 1'b0, d_prev = 1'b1;
  logic [7:0] d_byte;
  logic [7:0] dec_q[$];
  int         dec_t[$];

  always @(negedge i_clk) begin
    if (!i_rst || !dec_on) d_act = 1'b0;
    else if (!d_act) begin
      if (d_prev && !o_uart_tx) begin d_act = 1'b1; d_cnt = 0; dec_t.push_back(cyc); end
    end else begin
      d_cnt++;
      if (d_cnt >= d_div / 2 && (d_cnt - d_div / 2) % d_div == 0) begin
        dk = (d_cnt - d_div / 2) / d_div;
        if (dk == 0) chk("start_bit", o_uart_tx, 0);
        else if (dk <= 8) d_byte[dk-1] = o_uart_tx;
        else begin
          chk("stop_bit", o_uart_tx, 1);
          dec_q.push_back(d_byte);
          d_act = 1'b0;
        end
      end
    end
    d_prev = o_uart_tx;
  end

  task automatic tick(int n);
    repeat (n) @(negedge i_clk);
  endtask

  task automatic write_byte(logic [7:0] b);
    i_wr_en = 1'b1; i_data_tx = b; tick(1); i_wr_en = 1'b0;
  endtask

  task automatic do_reset(int n);
    i_rst = 1'b0; i_wr_en = 1'b1;
    tick(1);
    chk("rst_tx", o_uart_tx, 1);
    chk("rst_full", o_tx_full, 0);
    if (n > 1) tick(n - 1);
    i_rst = 1'b1; i_wr_en = 1'b0;
  endtask

  task automatic wait_dec(int n, int budget, string name);
    int c = 0;
    while (dec_q.size() < n && c < budget) begin tick(1); c++; end
    chk(name, dec_q.size(), n);
  endtask

  task automatic dec_start(int div);
    d_div = div; dec_q.delete(); dec_t.delete(); dec_on = 1'b1;
  endtask

  initial begin
    bit saw_full;
    int c;
    logic [7:0] en_bytes [3];
    en_bytes[0] = 8'hA5; en_bytes[1] = 8'h3C; en_bytes[2] = 8'h81;

    // Reset with writes attempted
    i_en = 1'b1;
    tick(1);
    chk_on = 1'b1;
    do_reset(5);
    tick(5);
    chk("idle_after_rst", o_uart_tx, 1);
    chk("empty_after_rst", o_tx_full, 0);

    // Single byte
    i_baudrate = 16'd10;
    dec_start(10);
    write_byte(8'h4D);
    wait_dec(1, 150, "single_done");
    chk("single_byte", dec_q.size() > 0 ? dec_q[0] : 8'hxx, 8'h4D);
    tick(10);

    // Streaming at 347 clocks per bit
    i_baudrate = 16'd347;
    dec_start(347);
    saw_full = 1'b0;
    i_data_tx = 8'h4D; i_wr_en = 1'b1;
    c = 0;
    while (dec_q.size() < 3 && c < 3 * 3471 + 400) begin
      tick(1); c++;
      if (o_tx_full) saw_full = 1'b1;
    end
    i_wr_en = 1'b0;
    chk("stream_done", dec_q.size(), 3);
    chk("stream_saw_full", saw_full, 1);
    for (int i = 0; i < dec_q.size(); i++) chk("stream_byte", dec_q[i], 8'h4D);
    for (int i = 1; i < dec_t.size() && i < 3; i++)
      chk("stream_period", dec_t[i] - dec_t[i-1], 3471);
    dec_on = 1'b0;
    do_reset(2);
    tick(2);

    // Overflow burst
    i_baudrate = 16'd4;
    dec_start(4);
    for (int i = 0; i < 12; i++) begin
      i_wr_en = 1'b1; i_data_tx = 8'(i); tick(1);
    end
    i_wr_en = 1'b0;
    wait_dec(9, 9 * 41 + 100, "ovf_done");
    tick(200);
    chk("ovf_count", dec_q.size(), 9);
    for (int i = 0; i < dec_q.size() && i < 9; i++) chk("ovf_byte", dec_q[i], i);

    // Enable gating mid-frame
    i_baudrate = 16'd10;
    dec_start(10);
    for (int i = 0; i < 3; i++) begin
      i_wr_en = 1'b1; i_data_tx = en_bytes[i]; tick(1);
    end
    i_wr_en = 1'b0;
    tick(30);
    i_en = 1'b0;
    tick(200);
    chk("en_gate_count", dec_q.size(), 1);
    chk("en_gate_line", o_uart_tx, 1);
    i_en = 1'b1;
    wait_dec(3, 300, "en_resume_done");
    for (int i = 0; i < dec_q.size() && i < 3; i++) chk("en_byte", dec_q[i], en_bytes[i]);
    dec_on = 1'b0;
    tick(5);

    // Baud change during a frame, then reset mid-DATA of the next one
    i_baudrate = 16'd10;
    write_byte(8'h0F);
    write_byte(8'hF0);
    tick(20);
    i_baudrate = 16'd20;
    tick(180);
    do_reset(1);
    for (int i = 0; i < 30; i++) begin
      tick(1);
      chk("post_rst_idle", o_uart_tx, 1);
    end

    // Randomised traffic
    for (int i = 0; i < 4000; i++) begin
      i_en = ($urandom_range(0, 9) != 0);
      i_wr_en = ($urandom_range(0, 3) == 0);
      i_data_tx = 8'($urandom);
      if ($urandom_range(0, 199) == 0) i_baudrate = 16'($urandom_range(0, 5));
      i_rst = ($urandom_range(0, 999) != 0);
      tick(1);
    end
    i_rst = 1'b1; i_wr_en = 1'b0;
    tick(5);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
